// File: rtl/regfile_pkg.sv
// Shared types and constants for the scoreboarded register file.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 4;
  localparam bit R0_ZERO_DEF = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int depth_of(input int aw);
    return int'(32'd1 << aw);
  endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Soft-clear sequencer: walks every register address once, one per cycle.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_start,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        state_r;
  clr_state_e        state_nxt_s;
  logic [ADDR_W-1:0] cnt_r;
  logic [ADDR_W-1:0] cnt_nxt_s;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state and clear-write control; the counter wraps to zero on the terminal address
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    clr_start   = 1'b0;
    clr_we      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt_s = ST_CLEAR;
          cnt_nxt_s   = {ADDR_W{1'b0}};
          clr_start   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clr_we    = 1'b1;
        cnt_nxt_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (&cnt_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign clr_busy = (state_r == ST_CLEAR);
  assign clr_addr = cnt_r;

endmodule

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard and soft clear.
// Define REGFILE_BYPASS_EN to forward writeback data to matching reads in the same cycle.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter bit R0_ZERO = R0_ZERO_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] regs_r [0:DEPTH-1];
  logic [DEPTH-1:0]  pending_r;

  logic              clr_start_s;
  logic              clr_we_s;
  logic [ADDR_W-1:0] clr_addr_s;
  logic              wr_ok_s;
  logic              rsv_ok_s;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .clr_start (clr_start_s),
    .clr_we    (clr_we_s),
    .clr_addr  (clr_addr_s)
  );

  assign wr_ok_s  = wr_en  && !clr_busy && !(R0_ZERO && (wr_addr  == {ADDR_W{1'b0}}));
  assign rsv_ok_s = rsv_en && !clr_busy && !(R0_ZERO && (rsv_addr == {ADDR_W{1'b0}}));

  // Data array and scoreboard; a same-address reservation overrides the write's pending clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
      pending_r <= {DEPTH{1'b0}};
    end else begin
      if (clr_we_s) begin
        regs_r[clr_addr_s] <= {DATA_W{1'b0}};
      end else if (wr_ok_s) begin
        regs_r[wr_addr] <= wr_data;
      end
      if (clr_start_s) begin
        pending_r <= {DEPTH{1'b0}};
      end else begin
        if (wr_ok_s) begin
          pending_r[wr_addr] <= 1'b0;
        end
        if (rsv_ok_s) begin
          pending_r[rsv_addr] <= 1'b1;
        end
      end
    end
  end

  // Combinational read ports
  always_comb begin
    rd_data_a = regs_r[rd_addr_a];
    rd_busy_a = pending_r[rd_addr_a];
    rd_data_b = regs_r[rd_addr_b];
    rd_busy_b = pending_r[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok_s && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
      rd_busy_a = (rsv_ok_s && (rsv_addr == rd_addr_a)) ? pending_r[rd_addr_a] : 1'b0;
    end else begin
      rd_data_a = regs_r[rd_addr_a];
    end
    if (wr_ok_s && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
      rd_busy_b = (rsv_ok_s && (rsv_addr == rd_addr_b)) ? pending_r[rd_addr_b] : 1'b0;
    end else begin
      rd_data_b = regs_r[rd_addr_b];
    end
`endif
  end

endmodule
